// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: constants and the IF/ID register layout.
package mips_pipe_pkg;

   localparam logic [31:0] INST_NOP         = 32'h0000_0000;
   localparam logic [31:0] WORD_BYTES       = 32'd4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] link;
   } if_id_t;

   // Byte address forced onto a word boundary.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~(WORD_BYTES - 32'd1);
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold (stall) and flush (nop-load) controls.
module if_id_reg
   import mips_pipe_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   input  logic   hold,
   input  logic   flush,
   input  if_id_t d,
   output if_id_t q
);

   if_id_t q_reg;
   if_id_t q_next;

   // A flushed entry still records pc/link so a later debug view stays coherent.
   always_comb begin
      q_next = q_reg;
      if (!hold) begin
         q_next = d;
         if (flush) begin
            q_next.valid = 1'b0;
            q_next.instr = INST_NOP;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_reg <= '0;
      end else begin
         q_reg <= q_next;
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS IF stage: pc register, deferred redirects across stalls, IF/ID capture.
// Optional feature macro: BRANCH_DELAY_SLOT_EN (keeps the delay-slot word, link = pc+8).
module instruction_fetch_unit
   import mips_pipe_pkg::*;
#(
   parameter int          INST_ADDR_BITS = 8,
   parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT
) (
   input  logic                      clk,
   input  logic                      reset,
   output logic [INST_ADDR_BITS-1:0] inst_addr,
   input  logic [31:0]               inst_data,
   input  logic                      stall,
   input  logic                      redirect_valid,
   input  logic [31:0]               redirect_target,
   output logic [31:0]               fetch_pc,
   output logic                      id_valid,
   output logic [31:0]               id_instruction,
   output logic [31:0]               id_pc,
   output logic [31:0]               id_link
);

`ifdef BRANCH_DELAY_SLOT_EN
   localparam logic [31:0] LINK_OFFSET = 2 * WORD_BYTES;
   localparam logic        FLUSH_ON_REDIRECT = 1'b0;
`else
   localparam logic [31:0] LINK_OFFSET = WORD_BYTES;
   localparam logic        FLUSH_ON_REDIRECT = 1'b1;
`endif

   logic [31:0] pc_reg, pc_next;
   logic        pending_valid_reg, pending_valid_next;
   logic [31:0] pending_target_reg, pending_target_next;

   logic        redirect_now;
   logic        pending_apply;
   logic        apply;
   logic [31:0] target_eff;
   if_id_t      if_id_d;
   if_id_t      if_id_q;

   // A live redirect always beats a stored one; both only act when not stalled.
   assign redirect_now  = redirect_valid & ~stall;
   assign pending_apply = pending_valid_reg & ~stall & ~redirect_valid;
   assign apply         = redirect_now | pending_apply;
   assign target_eff    = redirect_now ? redirect_target : pending_target_reg;

   always_comb begin
      pc_next = pc_reg;
      if (apply) begin
         pc_next = word_align(target_eff);
      end else if (!stall) begin
         pc_next = pc_reg + WORD_BYTES;
      end
   end

   // Latest redirect seen during a stall wins; any unstalled cycle retires it.
   always_comb begin
      pending_valid_next  = pending_valid_reg;
      pending_target_next = pending_target_reg;
      if (stall) begin
         if (redirect_valid) begin
            pending_valid_next  = 1'b1;
            pending_target_next = redirect_target;
         end
      end else begin
         pending_valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_reg             <= RESET_PC;
         pending_valid_reg  <= 1'b0;
         pending_target_reg <= 32'h0;
      end else begin
         pc_reg             <= pc_next;
         pending_valid_reg  <= pending_valid_next;
         pending_target_reg <= pending_target_next;
      end
   end

   assign if_id_d.valid = 1'b1;
   assign if_id_d.instr = inst_data;
   assign if_id_d.pc    = pc_reg;
   assign if_id_d.link  = pc_reg + LINK_OFFSET;

   if_id_reg u_if_id_reg (
      .clk   (clk),
      .reset (reset),
      .hold  (stall),
      .flush (apply & FLUSH_ON_REDIRECT),
      .d     (if_id_d),
      .q     (if_id_q)
   );

   assign inst_addr      = pc_reg[INST_ADDR_BITS+1:2];
   assign fetch_pc       = pc_reg;
   assign id_valid       = if_id_q.valid;
   assign id_instruction = if_id_q.instr;
   assign id_pc          = if_id_q.pc;
   assign id_link        = if_id_q.link;

endmodule
